// File: rtl/iris_net_pkg.sv
// ---------------------------------------------------------------------------
// iris_net_pkg
// Shared definitions for the Iris network output stage.
//   DEFAULT_DATA_WIDTH  : default width of a signed neuron score (matches Y)
//   DEFAULT_NUM_CLASSES : default number of output neurons / classes
//   score_t             : one signed neuron score at the default width
//   state_t             : classifier FSM states (IDLE, LOAD, SCAN)
// ---------------------------------------------------------------------------
package iris_net_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_NUM_CLASSES = 3;

  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] score_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2
  } state_t;

endpackage : iris_net_pkg

// File: rtl/argmax_update.sv
// ---------------------------------------------------------------------------
// argmax_update
// Combinational compare/update of the running {best, best_idx, second}
// against one (score, idx) pair. Kept separate so an unrolled scan can chain
// several copies.
// Ports:
//   best, best_idx, second          : current running state
//   score, idx                      : candidate being examined
//   best_nxt, best_idx_nxt, second_nxt : updated running state
// ---------------------------------------------------------------------------
module argmax_update
  import iris_net_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IDX_W      = $clog2(DEFAULT_NUM_CLASSES)
) (
  input  logic signed [DATA_WIDTH-1:0] best,
  input  logic        [IDX_W-1:0]      best_idx,
  input  logic signed [DATA_WIDTH-1:0] second,
  input  logic signed [DATA_WIDTH-1:0] score,
  input  logic        [IDX_W-1:0]      idx,
  output logic signed [DATA_WIDTH-1:0] best_nxt,
  output logic        [IDX_W-1:0]      best_idx_nxt,
  output logic signed [DATA_WIDTH-1:0] second_nxt
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    best_nxt     = best;
    best_idx_nxt = best_idx;
    second_nxt   = second;
    // Strict compare: on a tie the earlier (lower) index keeps the win and
    // the tied value becomes the runner-up.
    if (score > best) begin
      second_nxt   = best;
      best_nxt     = score;
      best_idx_nxt = idx;
    end else if (score > second) begin
      second_nxt = score;
    end
  end

endmodule : argmax_update

// File: rtl/iris_argmax_classifier.sv
// ---------------------------------------------------------------------------
// iris_argmax_classifier
// Output-stage classifier behind the Iris output-layer neurons. On start it
// captures all class scores, scans them one class per enabled cycle and
// reports the winning class, its score, the margin over the runner-up and an
// ambiguity (tie) flag.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   En           : clock enable; when low every register holds
//   start        : one-cycle pulse, all neuron outputs valid
//   scores       : packed signed scores, class i at [i*DATA_WIDTH +: DATA_WIDTH]
//   busy         : high while loading or scanning
//   done         : one-cycle (enabled) pulse when a new result is written
//   class_valid  : result valid, from done until the next accepted start
//   class_idx    : index of the maximum score
//   max_score    : signed maximum score
//   margin       : unsigned best - second best, one bit wider than a score
//   ambiguous    : best equals second best
// ---------------------------------------------------------------------------
module iris_argmax_classifier
  import iris_net_pkg::*;
#(
  parameter  int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter  int NUM_CLASSES = DEFAULT_NUM_CLASSES,
  localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              En,
  input  logic                              start,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] scores,
  output logic                              busy,
  output logic                              done,
  output logic                              class_valid,
  output logic [IDX_W-1:0]                  class_idx,
  output logic [DATA_WIDTH-1:0]             max_score,
  output logic [DATA_WIDTH:0]               margin,
  output logic                              ambiguous
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                       state;
  logic signed [DATA_WIDTH-1:0] score_q [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0] best;
  logic        [IDX_W-1:0]      best_idx;
  logic signed [DATA_WIDTH-1:0] second;
  logic        [IDX_W-1:0]      cnt;

  logic signed [DATA_WIDTH-1:0] upd_best;
  logic        [IDX_W-1:0]      upd_best_idx;
  logic signed [DATA_WIDTH-1:0] upd_second;
  logic        [DATA_WIDTH:0]   upd_margin;

  argmax_update #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_argmax_update (
    .best         (best),
    .best_idx     (best_idx),
    .second       (second),
    .score        (score_q[cnt]),
    .idx          (cnt),
    .best_nxt     (upd_best),
    .best_idx_nxt (upd_best_idx),
    .second_nxt   (upd_second)
  );

  // Sign-extend both operands by one bit; best >= second always, so the
  // extended difference is a non-negative value that never overflows.
  assign upd_margin = {upd_best[DATA_WIDTH-1], upd_best}
                    - {upd_second[DATA_WIDTH-1], upd_second};

  // NOTE: all state below is written with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      class_valid <= 1'b0;
      class_idx   <= '0;
      max_score   <= '0;
      margin      <= '0;
      ambiguous   <= 1'b0;
      best        <= '0;
      best_idx    <= '0;
      second      <= '0;
      cnt         <= '0;
      // NOTE: the score array is small flop storage, not a RAM, so it is
      // cleared on reset like the rest of the datapath.
      for (int i = 0; i < NUM_CLASSES; i++) begin
        score_q[i] <= '0;
      end
    end else if (En) begin
      // done is a single enabled-cycle pulse; holding En low stretches it.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            class_valid <= 1'b0;
            busy        <= 1'b1;
            state       <= LOAD;
          end
        end

        LOAD: begin
          for (int i = 0; i < NUM_CLASSES; i++) begin
            score_q[i] <= scores[i*DATA_WIDTH +: DATA_WIDTH];
          end
          // Class 0 seeds the scan straight from the input bus, so the
          // scan starts at index 1.
          best     <= scores[DATA_WIDTH-1:0];
          best_idx <= '0;
          second   <= MOST_NEG;
          cnt      <= IDX_W'(1);
          state    <= SCAN;
        end

        SCAN: begin
          best     <= upd_best;
          best_idx <= upd_best_idx;
          second   <= upd_second;
          cnt      <= cnt + IDX_W'(1);
          if (cnt == LAST_IDX) begin
            // Results use the post-update values of the final step.
            class_idx   <= upd_best_idx;
            max_score   <= upd_best;
            margin      <= upd_margin;
            ambiguous   <= (upd_best == upd_second);
            class_valid <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : iris_argmax_classifier

// File: tb/tb_iris_argmax_classifier.sv
// ---------------------------------------------------------------------------
// tb_iris_argmax_classifier
// Self-checking bench: directed corner cases plus randomized score vectors
// (with optional random clock-enable gaps) compared against a plain
// arithmetic argmax model.
// ---------------------------------------------------------------------------
module tb_iris_argmax_classifier;

  localparam int DW = 8;
  localparam int NC = 3;
  localparam int IW = $clog2(NC);

  logic             clk;
  logic             rst;
  logic             En;
  logic             start;
  logic [NC*DW-1:0] scores;
  logic             busy;
  logic             done;
  logic             class_valid;
  logic [IW-1:0]    class_idx;
  logic [DW-1:0]    max_score;
  logic [DW:0]      margin;
  logic             ambiguous;

  int n_checks = 0;
  int n_fail   = 0;

  iris_argmax_classifier #(
    .DATA_WIDTH  (DW),
    .NUM_CLASSES (NC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .En          (En),
    .start       (start),
    .scores      (scores),
    .busy        (busy),
    .done        (done),
    .class_valid (class_valid),
    .class_idx   (class_idx),
    .max_score   (max_score),
    .margin      (margin),
    .ambiguous   (ambiguous)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               tag, act, act, exp, exp, $time);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [NC*DW-1:0] pack3(input int a, input int b, input int c);
    logic [DW-1:0] va, vb, vc;
    va = DW'(a);
    vb = DW'(b);
    vc = DW'(c);
    return {vc, vb, va};
  endfunction

  // Reference: argmax with lowest index on ties; runner-up is the largest of
  // all remaining classes.
  function automatic void ref_model(input logic [NC*DW-1:0] v, output int idx,
                                    output int mx, output int mg, output bit amb);
    int s [NC];
    int sec;
    for (int i = 0; i < NC; i++) s[i] = int'($signed(v[i*DW +: DW]));
    idx = 0;
    for (int i = 1; i < NC; i++) if (s[i] > s[idx]) idx = i;
    sec = -1000000;
    for (int i = 0; i < NC; i++) if (i != idx && s[i] > sec) sec = s[i];
    mx  = s[idx];
    mg  = mx - sec;
    amb = (mx == sec);
  endfunction

  task automatic check_result(input string tag, input logic [NC*DW-1:0] v);
    int idx, mx, mg;
    bit amb;
    logic [DW-1:0] mx_v;
    logic [DW:0]   mg_v;
    ref_model(v, idx, mx, mg, amb);
    mx_v = DW'(mx);
    mg_v = (DW+1)'(mg);
    check({tag, ".class_idx"},   32'(class_idx),   32'(idx));
    check({tag, ".max_score"},   32'(max_score),   32'(mx_v));
    check({tag, ".margin"},      32'(margin),      32'(mg_v));
    check({tag, ".ambiguous"},   32'(ambiguous),   32'(amb));
    check({tag, ".class_valid"}, 32'(class_valid), 32'd1);
    check({tag, ".busy"},        32'(busy),        32'd0);
  endtask

  // Start a classification at the current falling edge and wait for done.
  // Returns with done visible; optionally continues one cycle to confirm the
  // pulse ends.
  task automatic classify(input string tag, input logic [NC*DW-1:0] v,
                          input bit rand_en, input bit check_pulse);
    int en_edges;
    int waited;
    scores = v;
    start  = 1'b1;
    En     = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".accept_busy"},  32'(busy),        32'd1);
    check({tag, ".accept_valid"}, 32'(class_valid), 32'd0);
    en_edges = 0;
    waited   = 0;
    while (!done && waited < 200) begin
      En = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      if (En) en_edges++;
      waited++;
    end
    En = 1'b1;
    check({tag, ".done_seen"}, 32'(done), 32'd1);
    check({tag, ".latency"},   32'(en_edges), 32'(NC));
    check_result(tag, v);
    if (check_pulse) begin
      tick();
      check({tag, ".done_pulse_end"}, 32'(done),        32'd0);
      check({tag, ".valid_holds"},    32'(class_valid), 32'd1);
    end
  endtask

  initial begin
    logic [NC*DW-1:0] v;
    int dones;

    rst    = 1'b1;
    En     = 1'b0;
    start  = 1'b0;
    scores = '0;
    #1;
    check("reset.busy",        32'(busy),        32'd0);
    check("reset.done",        32'(done),        32'd0);
    check("reset.class_valid", 32'(class_valid), 32'd0);
    check("reset.class_idx",   32'(class_idx),   32'd0);
    check("reset.max_score",   32'(max_score),   32'd0);
    check("reset.margin",      32'(margin),      32'd0);
    check("reset.ambiguous",   32'(ambiguous),   32'd0);
    tick();
    tick();
    rst = 1'b0;
    En  = 1'b1;
    tick();

    // Basic function, ties, zero vector, signed extremes.
    classify("t1_basic", pack3(5, 20, 7), 1'b0, 1'b1);
    classify("t2_tie",   pack3(9, 9, 2),  1'b0, 1'b1);
    classify("t2_zero",  pack3(0, 0, 0),  1'b0, 1'b1);
    classify("t3_neg",   pack3(-128, -3, -100), 1'b0, 1'b1);
    classify("t3_wide",  pack3(127, -128, -128), 1'b0, 1'b1);

    // Enable stall mid-scan plus an ignored start while busy.
    v      = pack3(5, 20, 7);
    scores = v;
    start  = 1'b1;
    tick();                      // start accepted
    start = 1'b0;
    tick();                      // LOAD
    start = 1'b1;
    tick();                      // first SCAN step; start must be ignored
    start = 1'b0;
    En    = 1'b0;
    scores = pack3(100, 1, 1);   // must not disturb the captured scores
    repeat (4) tick();
    check("t4.stall_no_done", 32'(done), 32'd0);
    check("t4.stall_busy",    32'(busy), 32'd1);
    En = 1'b1;
    tick();
    check("t4.done", 32'(done), 32'd1);
    check_result("t4", v);
    En = 1'b0;
    repeat (2) tick();
    check("t4.done_stretched", 32'(done), 32'd1);
    En = 1'b1;
    tick();
    check("t4.done_cleared", 32'(done), 32'd0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) dones++;
    end
    check("t4.no_extra_done", 32'(dones), 32'd0);
    check("t4.idle_busy",     32'(busy),  32'd0);

    // Reset in the first SCAN cycle.
    scores = pack3(5, 20, 7);
    start  = 1'b1;
    tick();
    start = 1'b0;
    tick();                      // now in SCAN
    rst = 1'b1;
    #1;
    check("t5.rst_busy",        32'(busy),        32'd0);
    check("t5.rst_class_valid", 32'(class_valid), 32'd0);
    check("t5.rst_max_score",   32'(max_score),   32'd0);
    check("t5.rst_class_idx",   32'(class_idx),   32'd0);
    check("t5.rst_margin",      32'(margin),      32'd0);
    tick();
    rst   = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dones++;
    end
    check("t5.no_done_after_rst", 32'(dones), 32'd0);
    classify("t5_after", pack3(1, 2, 30), 1'b0, 1'b0);

    // Back-to-back: next start issued in the done cycle.
    classify("t6_b2b", pack3(40, 3, 41), 1'b0, 1'b1);

    // Randomized vectors, some with forced ties, half with enable gaps.
    for (int n = 0; n < 24; n++) begin
      int a, b, c;
      a = int'($urandom_range(0, 255)) - 128;
      b = int'($urandom_range(0, 255)) - 128;
      c = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 5) == 0) c = (a > b) ? a : b;
      classify($sformatf("rand%0d", n), pack3(a, b, c), n[0], n[1]);
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_iris_argmax_classifier
